// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element family.
// Purpose: width helpers and a generic saturate function reused by the
//          MAC cell and by accumulator/bias blocks.
// Contents:
//   prod_w(data_w)        full signed product width (2*data_w)
//   sum_w(data_w, acc_w)  exact sum width: max(prod_w, acc_w) + 1
//   saturate(v, w, en)    range-checks v against a w-bit signed range;
//                         returns {value, ovf}, clamping only when en=1
package pe_pkg;

    // Widest value the saturate helper accepts; callers sign-extend into it.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             ovf;
    } sat_t;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_w(input int data_w, input int acc_w);
        return ((2 * data_w > acc_w) ? 2 * data_w : acc_w) + 1;
    endfunction

    // Out-of-range is flagged regardless of sat_en. Without clamping the
    // value passes through untouched, so taking its low bits yields the
    // two's-complement wrap.
    function automatic sat_t saturate(input logic signed [MAX_W-1:0] value,
                                      input int width,
                                      input logic sat_en);
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        sat_t                    res;
        max_v     = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (width - 1));
        res.value = value;
        res.ovf   = 1'b0;
        if (value > max_v) begin
            res.ovf = 1'b1;
            if (sat_en) res.value = max_v;
        end else if (value < min_v) begin
            res.ovf = 1'b1;
            if (sat_en) res.value = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_signed_mult.sv
// Combinational signed multiplier producing the full-width product.
// Ports:
//   a_i  DATA_W    signed multiplicand
//   b_i  DATA_W    signed multiplier
//   p_o  2*DATA_W  signed product (never truncated)
module pe_signed_mult #(
    parameter int DATA_W = 8
) (
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    // Operands are widened to the product width first, so the multiply is
    // evaluated at full precision.
    assign p_o = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);

endmodule

// File: rtl/pe_mac_array_cell.sv
// Weight-stationary MAC cell for a systolic array.
// Activations pass west->east, partial sums and shadow weights north->south.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               global advance; 0 freezes everything except ovf_clr
//   act_in/_valid_in activation and MAC qualifier from west
//   psum_in          partial sum from north
//   wt_in/wt_shift   shadow-weight chain input and its shift strobe
//   wt_swap          copy shadow weight into the active weight
//   ovf_clr          clear sticky overflow
//   act_out/_valid   registered activation to east
//   psum_out/_valid  MAC result to south (1+PIPE cycles of latency)
//   wt_out           shadow register, chained to the cell below
//   ovf              sticky overflow
module pe_mac_array_cell
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SAT_EN = 1,
    parameter int PIPE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] act_in,
    input  logic                     act_valid_in,
    input  logic signed [ACC_W-1:0]  psum_in,
    input  logic signed [DATA_W-1:0] wt_in,
    input  logic                     wt_shift,
    input  logic                     wt_swap,
    input  logic                     ovf_clr,
    output logic signed [DATA_W-1:0] act_out,
    output logic                     act_valid_out,
    output logic signed [ACC_W-1:0]  psum_out,
    output logic                     psum_valid_out,
    output logic signed [DATA_W-1:0] wt_out,
    output logic                     ovf
);

    localparam int PROD_W = prod_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W, ACC_W);

    logic signed [DATA_W-1:0] act_q;
    logic                     act_valid_q;
    logic signed [DATA_W-1:0] shadow_q;
    logic signed [DATA_W-1:0] active_q;
    logic signed [ACC_W-1:0]  psum_q;
    logic                     psum_valid_q;
    logic                     ovf_q;

    // The product always uses the weight active at issue time, so a MAC in
    // the swap cycle still sees the old weight.
    logic signed [PROD_W-1:0] prod;

    pe_signed_mult #(
        .DATA_W(DATA_W)
    ) u_mult (
        .a_i(act_in),
        .b_i(active_q),
        .p_o(prod)
    );

    // Operands presented to the add/saturate stage.
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [ACC_W-1:0]  s2_psum;
    logic                     s2_valid;

    generate
        if (PIPE == 1) begin : g_pipe
            logic signed [PROD_W-1:0] prod_q;
            logic signed [ACC_W-1:0]  psum_s1_q;
            logic                     valid_s1_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_q     <= '0;
                    psum_s1_q  <= '0;
                    valid_s1_q <= 1'b0;
                end else if (en) begin
                    prod_q     <= prod;
                    psum_s1_q  <= psum_in;
                    valid_s1_q <= act_valid_in;
                end
            end

            assign s2_prod  = prod_q;
            assign s2_psum  = psum_s1_q;
            assign s2_valid = valid_s1_q;
        end else begin : g_nopipe
            assign s2_prod  = prod;
            assign s2_psum  = psum_in;
            assign s2_valid = act_valid_in;
        end
    endgenerate

    // Sum is one bit wider than either operand, so it cannot overflow
    // itself; range checking happens on this exact value.
    logic signed [SUM_W-1:0] sum;
    sat_t                    sat_res;
    logic signed [ACC_W-1:0] psum_d;
    logic                    ovf_hit;
    logic                    unused_sat_bits;

    assign sum             = SUM_W'(s2_prod) + SUM_W'(s2_psum);
    assign sat_res         = saturate(MAX_W'(sum), ACC_W, SAT_EN != 0);
    assign psum_d          = sat_res.value[ACC_W-1:0];
    assign ovf_hit         = sat_res.ovf;
    assign unused_sat_bits = ^sat_res.value[MAX_W-1:ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (en) begin
                act_q        <= act_in;
                act_valid_q  <= act_valid_in;
                if (wt_shift) shadow_q <= wt_in;
                // Reads the pre-edge shadow, so shift+swap moves the old
                // shadow into active while wt_in lands in shadow.
                if (wt_swap)  active_q <= shadow_q;
                psum_valid_q <= s2_valid;
                if (s2_valid) psum_q <= psum_d;
            end
            // A new overflow beats a simultaneous clear; clear ignores en.
            if (en && s2_valid && ovf_hit) ovf_q <= 1'b1;
            else if (ovf_clr)              ovf_q <= 1'b0;
        end
    end

    assign act_out        = act_q;
    assign act_valid_out  = act_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign wt_out         = shadow_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_pe_mac_array_cell.sv
// Bench for pe_mac_array_cell: three instances share one stimulus stream
// (saturating PIPE=0, wrapping PIPE=0, saturating PIPE=1). Expected MAC
// results are pushed per instance at issue time; monitors pop on each
// enabled-edge psum_valid_out and compare psum and ovf.
module tb_pe_mac_array_cell;

    typedef struct {
        logic signed [15:0] psum;
        logic               ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic signed [7:0]  act_in;
    logic               act_valid_in;
    logic signed [15:0] psum_in;
    logic signed [7:0]  wt_in;
    logic               wt_shift;
    logic               wt_swap;
    logic               ovf_clr;

    logic signed [7:0]  d_act, w_act, p_act;
    logic               d_av, w_av, p_av;
    logic signed [15:0] d_psum, w_psum, p_psum;
    logic               d_pv, w_pv, p_pv;
    logic signed [7:0]  d_wt, w_wt, p_wt;
    logic               d_ovf, w_ovf, p_ovf;

    int checks   = 0;
    int failures = 0;

    exp_t q_d[$];
    exp_t q_w[$];
    exp_t q_p[$];
    exp_t e_d, e_w, e_p;
    logic fire = 1'b0;

    always #5 clk = ~clk;

    pe_mac_array_cell #(.DATA_W(8), .ACC_W(16), .SAT_EN(1), .PIPE(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
        .psum_in(psum_in), .wt_in(wt_in), .wt_shift(wt_shift), .wt_swap(wt_swap),
        .ovf_clr(ovf_clr), .act_out(d_act), .act_valid_out(d_av), .psum_out(d_psum),
        .psum_valid_out(d_pv), .wt_out(d_wt), .ovf(d_ovf));

    pe_mac_array_cell #(.DATA_W(8), .ACC_W(16), .SAT_EN(0), .PIPE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
        .psum_in(psum_in), .wt_in(wt_in), .wt_shift(wt_shift), .wt_swap(wt_swap),
        .ovf_clr(ovf_clr), .act_out(w_act), .act_valid_out(w_av), .psum_out(w_psum),
        .psum_valid_out(w_pv), .wt_out(w_wt), .ovf(w_ovf));

    pe_mac_array_cell #(.DATA_W(8), .ACC_W(16), .SAT_EN(1), .PIPE(1)) u_pipe (
        .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
        .psum_in(psum_in), .wt_in(wt_in), .wt_shift(wt_shift), .wt_swap(wt_swap),
        .ovf_clr(ovf_clr), .act_out(p_act), .act_valid_out(p_av), .psum_out(p_psum),
        .psum_valid_out(p_pv), .wt_out(p_wt), .ovf(p_ovf));

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic signed [7:0] a, input logic av,
                        input logic signed [15:0] p, input logic signed [7:0] w,
                        input logic sh, input logic sw, input logic clr);
        en = e; act_in = a; act_valid_in = av; psum_in = p;
        wt_in = w; wt_shift = sh; wt_swap = sw; ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e, input logic clr);
        step(e, 8'sd0, 1'b0, 16'sd0, 8'sd0, 1'b0, 1'b0, clr);
    endtask

    task automatic push3(input int pd, input logic od, input int pw, input logic ow,
                         input int pp, input logic op);
        exp_t x;
        x.psum = 16'(pd); x.ovf = od; q_d.push_back(x);
        x.psum = 16'(pw); x.ovf = ow; q_w.push_back(x);
        x.psum = 16'(pp); x.ovf = op; q_p.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d_act"},  d_act, 0);
        check({tag, "_d_av"},   d_av, 0);
        check({tag, "_d_psum"}, d_psum, 0);
        check({tag, "_d_pv"},   d_pv, 0);
        check({tag, "_d_wt"},   d_wt, 0);
        check({tag, "_d_ovf"},  d_ovf, 0);
        check({tag, "_p_act"},  p_act, 0);
        check({tag, "_p_av"},   p_av, 0);
        check({tag, "_p_psum"}, p_psum, 0);
        check({tag, "_p_pv"},   p_pv, 0);
        check({tag, "_p_wt"},   p_wt, 0);
        check({tag, "_p_ovf"},  p_ovf, 0);
    endtask

    // A result counts as a new output only after an enabled, non-reset edge.
    always @(posedge clk) fire <= en && !rst;

    always @(negedge clk) begin
        if (fire && d_pv) begin
            if (q_d.size() == 0) begin
                checks++; failures++;
                $display("FAIL sat_pipe0_unexpected: got psum=%0d, expected no output", d_psum);
            end else begin
                e_d = q_d.pop_front();
                check("sat_pipe0_psum", d_psum, e_d.psum);
                check("sat_pipe0_ovf", d_ovf, e_d.ovf);
            end
        end
        if (fire && w_pv) begin
            if (q_w.size() == 0) begin
                checks++; failures++;
                $display("FAIL wrap_pipe0_unexpected: got psum=%0d, expected no output", w_psum);
            end else begin
                e_w = q_w.pop_front();
                check("wrap_pipe0_psum", w_psum, e_w.psum);
                check("wrap_pipe0_ovf", w_ovf, e_w.ovf);
            end
        end
        if (fire && p_pv) begin
            if (q_p.size() == 0) begin
                checks++; failures++;
                $display("FAIL sat_pipe1_unexpected: got psum=%0d, expected no output", p_psum);
            end else begin
                e_p = q_p.pop_front();
                check("sat_pipe1_psum", p_psum, e_p.psum);
                check("sat_pipe1_ovf", p_ovf, e_p.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en = 1'b0; act_in = '0; act_valid_in = 1'b0; psum_in = '0;
        wt_in = '0; wt_shift = 1'b0; wt_swap = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Basic MAC: weight 3, act -5, psum 10 -> -5
        step(1, 0, 0, 0, 8'sd3, 1, 0, 0);
        check("load_wt_out", d_wt, 3);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        push3(-5, 0, -5, 0, -5, 0);
        step(1, -8'sd5, 1, 16'sd10, 0, 0, 0, 0);
        check("act_out", d_act, -5);
        check("act_valid_out", d_av, 1);
        idle(1, 0);
        check("idle_psum_hold", d_psum, -5);
        check("idle_valid_low", d_pv, 0);

        // Saturation / wrap in both directions, weight -128
        step(1, 0, 0, 0, -8'sd128, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        push3(32767, 1, -29152, 1, 32767, 1);
        step(1, -8'sd128, 1, 16'sd20000, 0, 0, 0, 0);
        push3(-32768, 1, 29280, 1, -32768, 1);
        step(1, 8'sd127, 1, -16'sd20000, 0, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);

        // Clear with en=0
        idle(0, 1);
        check("clr_noen_d", d_ovf, 0);
        check("clr_noen_w", w_ovf, 0);
        check("clr_noen_p", p_ovf, 0);

        // Clear coinciding with a new overflow: set wins
        push3(32767, 1, -29152, 1, 32767, 1);
        step(1, -8'sd128, 1, 16'sd20000, 0, 0, 0, 1);
        idle(1, 1);
        check("clr_after_d", d_ovf, 0);
        check("clr_collide_p", p_ovf, 1);
        idle(1, 1);
        check("clr_after_p", p_ovf, 0);

        // Shift/swap collision: active=2, shadow=7
        step(1, 0, 0, 0, 8'sd2, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 8'sd7, 1, 0, 0);
        push3(2, 0, 2, 0, 2, 0);
        step(1, 8'sd1, 1, 16'sd0, 8'sd9, 1, 1, 0);
        check("collide_wt_out", d_wt, 9);
        push3(7, 0, 7, 0, 7, 0);
        step(1, 8'sd1, 1, 16'sd0, 0, 0, 0, 0);

        // Stall: issue 3*7+1 = 22, then freeze for 3 cycles
        push3(22, 0, 22, 0, 22, 0);
        step(1, 8'sd3, 1, 16'sd1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'(5 + i), 1'(i), 16'sd100, 8'sd11, 1, 1, 0);
            check("stall_act", d_act, 3);
            check("stall_av", d_av, 1);
            check("stall_psum", d_psum, 22);
            check("stall_pv", d_pv, 1);
            check("stall_wt", d_wt, 9);
            check("stall_pipe_psum", p_psum, 7);
        end
        push3(7, 0, 7, 0, 7, 0);
        step(1, 8'sd1, 1, 16'sd0, 0, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);

        // Reset with a PIPE=1 MAC in flight
        step(1, 8'sd1, 1, 16'sd5, 8'sd4, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        check_zero("midrst");
        idle(1, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1, 0);
            check("post_rst_pipe_pv", p_pv, 0);
        end

        check("queue_left_d", q_d.size(), 0);
        check("queue_left_w", q_w.size(), 0);
        check("queue_left_p", q_p.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
